gmii_rx_frame_ctrl: RTL and testbench
=====================================

// Module: gmii_rx_frame_ctrl
// PURPOSE
//  Receive-side frame sequencer behind the RGMII->GMII DDR capture stage, in the gmii_rx_clk domain.
//  Hunts preamble/SFD on the 8-bit GMII byte stream, strips them, and emits frame bytes with sop/eop.
//  Tracks length and checks the destination MAC filter.
//  Issues one status pulse per frame and keeps good/bad frame counters for the ARP/UDP receive logic.
// PARAMETERS
//  LOCAL_MAC  48'h00_0A_35_01_FE_C0  station address for destination filter
//  MIN_LEN    64                     min legal frame bytes (DA..FCS inclusive)
//  MAX_LEN    1518                   max legal frame bytes (DA..FCS inclusive)
//  MAX_PRE    15                     max 0x55 bytes tolerated before SFD
// PORTS
//  clk          in   1   gmii_rx_clk (125 MHz)
//  rst_n        in   1   async active-low reset
//  gmii_rx_dv   in   1   byte valid from DDR capture
//  gmii_rx_data in   8   received byte
//  promisc      in   1   1 = accept any DA (addr_ok forced 1)
//  rx_data      out  8   frame byte (DA first, FCS last)
//  rx_valid     out  1   rx_data valid this cycle
//  rx_sop       out  1   first byte of frame (with rx_valid)
//  rx_eop       out  1   last byte of frame (with rx_valid)
//  frame_done   out  1   1-cycle status strobe, cycle after rx_eop
//  frame_len    out  11  byte count DA..FCS, saturates at 2047; valid with frame_done
//  frame_stat   out  4   {crc_err, len_err, pre_err, addr_ok}; valid with frame_done
//  good_cnt     out  16  frames with stat[3:1]==0, saturating
//  bad_cnt      out  16  frames with any of stat[3:1] set, saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Async assert; any frame in flight is abandoned silently.
//  FSM states:
//   IDLE:     dv&&data==8'h55 -> PRE (pre_cnt=1); dv&&other -> DROP; else stay.
//   PRE:      dv&&8'h55 -> pre_cnt++, stay; pre_cnt>MAX_PRE -> DROP.
//             dv&&8'hD5 -> DATA. dv&&other -> DROP. !dv -> IDLE, no strobe.
//   DATA:     dv -> capture byte. !dv -> FLUSH.
//   FLUSH:    drains held byte with rx_eop -> DONE.
//   DONE:     frame_done=1 for 1 cycle, counters update -> IDLE (or PRE if dv&&8'h55).
//   DROP:     wait for !dv -> IDLE. No data output.
//             pre_err frames are not delivered; bad_cnt increments once on exit.
//  Datapath:
//   1-byte hold register, so eop rides on the last byte.
//   Byte sampled at edge n appears on rx_data at n+2 with rx_valid=1.
//   rx_valid is contiguous for the whole frame.
//   1-byte frame: rx_sop and rx_eop in the same cycle.
//   SFD followed immediately by !dv: no rx_valid; frame_done with len=0, len_err=1.
//  Length: counts every DATA byte; len_err = len<MIN_LEN || len>MAX_LEN. Bytes past MAX_LEN still forwarded.
//  Addr: addr_ok = promisc || DA==LOCAL_MAC || DA==48'hFFFF_FFFF_FFFF. Compare bytewise while len<6.
//    Frames shorter than 6 bytes: addr_ok=0. addr_ok does not affect good/bad counting.
//  Counters saturate at 16'hFFFF, never wrap. dv glitch in PRE is not counted.
// CONFIGURATION
//  RX_CRC_CHECK_EN defined:
//   CRC-32 over DA..FCS: reflected poly 32'hEDB88320, init 32'hFFFF_FFFF, one byte per clk.
//   crc_err = (residue != 32'hDEBB20E3) at FLUSH.
//  RX_CRC_CHECK_EN undefined: no CRC logic; crc_err tied 0.
//  Timing and FCS forwarding are identical in both builds.
// STRUCTURE
//  Package gmii_rx_pkg: FSM state enum, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5,
//   CRC_POLY, CRC_INIT, CRC_RESIDUE, STAT_* bit indices.
//  Sub-module crc32_d8: combinational next-CRC from (crc_in[31:0], byte[7:0]).
//   Instantiated only under RX_CRC_CHECK_EN.
// TESTING
//  1. 7x55,D5, 60-byte broadcast frame with valid FCS (64 total):
//     64 rx_valid, sop on 1st, eop on 64th; len=64, stat=4'b0001, good_cnt=1.
//  2. Same frame, one payload bit flipped:
//     CRC_EN build stat=4'b1001, bad_cnt=1; non-CRC build stat=4'b0001, good_cnt=1.
//  3. 7x55,D5, 40-byte frame, DA=LOCAL_MAC: len=40, stat=4'b0101.
//     1600-byte frame: len=1600, len_err=1, all 1600 bytes forwarded.
//  4. 7x55 then 8'hAA then 50 bytes: DROP, no rx_valid, bad_cnt+1, pre_err=1.
//     Then 55,55,dv low: IDLE, no strobe.
//  5. DA=12:34:56:78:9A:BC with promisc=0: addr_ok=0; same frame with promisc=1: addr_ok=1.
//  6. rst_n low for 1 cycle mid-DATA: outputs 0 immediately, no frame_done.
//     Next frame received cleanly. Back-to-back frames with 2-cycle IFG both delivered.

Source files
------------

// File: rtl/gmii_rx_pkg.sv
// rtl/gmii_rx_pkg.sv - shared types and constants for the GMII receive frame sequencer
package gmii_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_FLUSH,
    ST_DONE,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  localparam int STAT_ADDR_OK = 0;
  localparam int STAT_PRE_ERR = 1;
  localparam int STAT_LEN_ERR = 2;
  localparam int STAT_CRC_ERR = 3;

  // Frame counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide reflected CRC-32 next-state, present only with RX_CRC_CHECK_EN
`ifdef RX_CRC_CHECK_EN
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Eight LSB-first shift steps of the reflected polynomial, unrolled.
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
    end
  end

endmodule
`endif

// File: rtl/gmii_rx_frame_ctrl.sv
// rtl/gmii_rx_frame_ctrl.sv - GMII preamble/SFD hunt, frame delimiting, DA filter and status (optional CRC: RX_CRC_CHECK_EN)
module gmii_rx_frame_ctrl
  import gmii_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518,
  parameter int          MAX_PRE   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rx_data,
  input  logic        promisc,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic [3:0]  frame_stat,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [4:0]  PRE_LIM = 5'(MAX_PRE);

  rx_state_e   state;
  logic [4:0]  pre_cnt;
  logic [7:0]  hold_data;
  logic        hold_v;
  logic        first_q;
  logic [10:0] len_q;
  logic        match_local_q;
  logic        match_bc_q;
  logic [7:0]  mac_byte;
  logic        crc_err_w;
  logic        len_err_w;
  logic        addr_ok_w;
  logic [3:0]  stat_w;

  // Station address byte expected at the current DA position (DA[0] is the MSB octet).
  always_comb begin
    mac_byte = 8'h00;
    case (len_q[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      3'd5:    mac_byte = LOCAL_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_next;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rx_data),
    .crc_out (crc_next)
  );

  // Running CRC over DA..FCS; seeded on SFD, advanced once per captured byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else if (state == ST_PRE && gmii_rx_dv && gmii_rx_data == SFD_BYTE) begin
      crc_q <= CRC_INIT;
    end else if (state == ST_DATA && gmii_rx_dv) begin
      crc_q <= crc_next;
    end
  end

  assign crc_err_w = (crc_q != CRC_RESIDUE);
`else
  assign crc_err_w = 1'b0;
`endif

  assign len_err_w = (len_q < MIN_L) || (len_q > MAX_L);
  assign addr_ok_w = promisc || ((len_q >= 11'd6) && (match_local_q || match_bc_q));

  // Assemble the per-frame status word from its named bit positions.
  always_comb begin
    stat_w               = 4'b0000;
    stat_w[STAT_CRC_ERR] = crc_err_w;
    stat_w[STAT_LEN_ERR] = len_err_w;
    stat_w[STAT_ADDR_OK] = addr_ok_w;
  end

  // Frame sequencer: state, one-byte hold stage, registered stream outputs, status and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pre_cnt       <= 5'd0;
      hold_data     <= 8'h00;
      hold_v        <= 1'b0;
      first_q       <= 1'b0;
      len_q         <= 11'd0;
      match_local_q <= 1'b0;
      match_bc_q    <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_sop        <= 1'b0;
      rx_eop        <= 1'b0;
      frame_done    <= 1'b0;
      frame_len     <= 11'd0;
      frame_stat    <= 4'b0000;
      good_cnt      <= 16'd0;
      bad_cnt       <= 16'd0;
    end else begin
      rx_valid   <= 1'b0;
      rx_sop     <= 1'b0;
      rx_eop     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gmii_rx_dv) begin
            if (gmii_rx_data == PREAMBLE_BYTE) begin
              state   <= ST_PRE;
              pre_cnt <= 5'd1;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_PRE: begin
          if (!gmii_rx_dv) begin
            // Carrier glitch inside the preamble: forget it, no status.
            state <= ST_IDLE;
          end else if (gmii_rx_data == PREAMBLE_BYTE) begin
            if (pre_cnt >= PRE_LIM) begin
              state <= ST_DROP;
            end else begin
              pre_cnt <= pre_cnt + 5'd1;
            end
          end else if (gmii_rx_data == SFD_BYTE) begin
            state         <= ST_DATA;
            hold_v        <= 1'b0;
            first_q       <= 1'b1;
            len_q         <= 11'd0;
            match_local_q <= 1'b1;
            match_bc_q    <= 1'b1;
          end else begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (hold_v) begin
            // The held byte leaves now; it is the last one if the carrier just dropped.
            rx_data  <= hold_data;
            rx_valid <= 1'b1;
            rx_sop   <= first_q;
            rx_eop   <= !gmii_rx_dv;
            first_q  <= 1'b0;
          end
          if (gmii_rx_dv) begin
            hold_data <= gmii_rx_data;
            hold_v    <= 1'b1;
            if (len_q != 11'h7FF) begin
              len_q <= len_q + 11'd1;
            end
            if (len_q < 11'd6) begin
              match_local_q <= match_local_q && (gmii_rx_data == mac_byte);
              match_bc_q    <= match_bc_q && (gmii_rx_data == 8'hFF);
            end
          end else begin
            hold_v <= 1'b0;
            state  <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          frame_done <= 1'b1;
          frame_len  <= len_q;
          frame_stat <= stat_w;
          if (stat_w[STAT_CRC_ERR] || stat_w[STAT_LEN_ERR]) begin
            bad_cnt <= sat_inc16(bad_cnt);
          end else begin
            good_cnt <= sat_inc16(good_cnt);
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (gmii_rx_dv && gmii_rx_data == PREAMBLE_BYTE) begin
            state   <= ST_PRE;
            pre_cnt <= 5'd1;
          end else if (gmii_rx_dv) begin
            state <= ST_DROP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!gmii_rx_dv) begin
            // A rejected burst still gets exactly one status strobe and one bad count.
            frame_done             <= 1'b1;
            frame_len              <= 11'd0;
            frame_stat             <= 4'b0000;
            frame_stat[STAT_PRE_ERR] <= 1'b1;
            bad_cnt                <= sat_inc16(bad_cnt);
            state                  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// tb/tb_gmii_rx_frame_ctrl.sv - directed table-driven bench for gmii_rx_frame_ctrl
module tb_gmii_rx_frame_ctrl;

`ifdef RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rx_data = 8'h00;
  logic        promisc = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        frame_done;
  logic [10:0] frame_len;
  logic [3:0]  frame_stat;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_frame_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rx_data (gmii_rx_data),
    .promisc      (promisc),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_sop       (rx_sop),
    .rx_eop       (rx_eop),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .frame_stat   (frame_stat),
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: cumulative record of everything the DUT emits, sampled mid-cycle.
  logic [7:0] rxq[$];
  int sop_cnt = 0, eop_cnt = 0, done_cnt = 0, run_cnt = 0;
  int sop_idx = -1, eop_idx = -1, sop_cyc = 0;
  logic [10:0] last_len = 11'd0;
  logic [3:0]  last_stat = 4'd0;
  logic        prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (!prev_valid) run_cnt = run_cnt + 1;
        if (rx_sop) begin
          sop_cnt = sop_cnt + 1;
          sop_idx = rxq.size();
          sop_cyc = cyc;
        end
        if (rx_eop) begin
          eop_cnt = eop_cnt + 1;
          eop_idx = rxq.size();
        end
        rxq.push_back(rx_data);
      end
      if (frame_done) begin
        done_cnt  = done_cnt + 1;
        last_len  = frame_len;
        last_stat = frame_stat;
      end
    end
    prev_valid = rst_n && rx_valid;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int good_exp = 0;
  int bad_exp = 0;
  int da_cyc = 0;
  logic [7:0] fb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Frame image DA..FCS; totals below 16 are raw filler bytes with no FCS.
  task automatic build_frame(input int total, input int da_sel, input bit corrupt);
    logic [31:0] c;
    logic [47:0] da;
    fb.delete();
    if (total < 16) begin
      for (int i = 0; i < total; i++) fb.push_back(8'h42);
      return;
    end
    da = (da_sel == 0) ? 48'hFFFF_FFFF_FFFF : (da_sel == 1) ? 48'h000A_3501_FEC0 : 48'h1234_5678_9ABC;
    for (int i = 0; i < 6; i++) fb.push_back(da[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back((i == 0) ? 8'h02 : (i == 5) ? 8'h01 : 8'h00);
    for (int i = 0; i < total - 16; i++) fb.push_back(8'(i * 7 + 3));
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < fb.size(); i++) c = crc_byte(c, fb[i]);
    c = ~c;
    fb.push_back(c[7:0]);
    fb.push_back(c[15:8]);
    fb.push_back(c[23:16]);
    fb.push_back(c[31:24]);
    if (corrupt) fb[14] = fb[14] ^ 8'h01;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    @(posedge clk);
    #1;
    gmii_rx_dv   = dv;
    gmii_rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  // Preamble, SFD, frame image, then one cycle with dv low.
  task automatic send(input int pre_n);
    for (int i = 0; i < pre_n; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < fb.size(); i++) begin
      drive(1'b1, fb[i]);
      if (i == 0) da_cyc = cyc;
    end
    drive(1'b0, 8'h00);
  endtask

  typedef struct {
    string      tag;
    int         pre_n;
    int         total;
    int         da_sel;
    bit         corrupt;
    bit         prom;
    int         exp_rx;
    int         exp_len;
    logic [3:0] exp_stat;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v);
    int base, sop0, eop0, done0, run0, mm;
    logic [3:0] es;
    es = v.exp_stat | ((v.corrupt && CRC_EN) ? 4'b1000 : 4'b0000);
    if (es[3:1] == 3'b000) good_exp++; else bad_exp++;
    base = rxq.size(); sop0 = sop_cnt; eop0 = eop_cnt; done0 = done_cnt; run0 = run_cnt;
    promisc = v.prom;
    build_frame(v.total, v.da_sel, v.corrupt);
    send(v.pre_n);
    idle(8);
    check({v.tag, ".rx_bytes"}, 64'(rxq.size() - base), 64'(v.exp_rx));
    check({v.tag, ".done"}, 64'(done_cnt - done0), 64'd1);
    check({v.tag, ".len"}, 64'(last_len), 64'(v.exp_len));
    check({v.tag, ".stat"}, 64'(last_stat), 64'(es));
    check({v.tag, ".good"}, 64'(good_cnt), 64'(good_exp));
    check({v.tag, ".bad"}, 64'(bad_cnt), 64'(bad_exp));
    check({v.tag, ".sops"}, 64'(sop_cnt - sop0), (v.exp_rx > 0) ? 64'd1 : 64'd0);
    if (v.exp_rx > 0) begin
      check({v.tag, ".sop_pos"}, 64'(sop_idx), 64'(base));
      check({v.tag, ".eop_pos"}, 64'(eop_idx), 64'(base + v.exp_rx - 1));
      check({v.tag, ".eops"}, 64'(eop_cnt - eop0), 64'd1);
      check({v.tag, ".runs"}, 64'(run_cnt - run0), 64'd1);
      // First DA byte sampled at the edge after da_cyc; visible after the following edge.
      check({v.tag, ".latency"}, 64'(sop_cyc), 64'(da_cyc + 2));
      mm = 0;
      for (int i = 0; i < v.exp_rx; i++) if (rxq[base + i] !== fb[i]) mm++;
      check({v.tag, ".data"}, 64'(mm), 64'd0);
    end
  endtask

  initial begin
    int base, done0;
    //          tag       pre total da cor prm rx    len   stat
    vecs[0]  = '{"bc64",   7,  64,  0, 0, 0,  64,   64,  4'b0001};
    vecs[1]  = '{"bc64x",  7,  64,  0, 1, 0,  64,   64,  4'b0001};
    vecs[2]  = '{"loc40",  7,  40,  1, 0, 0,  40,   40,  4'b0101};
    vecs[3]  = '{"oth64",  7,  64,  2, 0, 0,  64,   64,  4'b0000};
    vecs[4]  = '{"othpr",  7,  64,  2, 0, 1,  64,   64,  4'b0001};
    vecs[5]  = '{"bc1600", 7,  1600, 0, 0, 0, 1600, 1600, 4'b0101};
    vecs[6]  = '{"loc1518",15, 1518, 1, 0, 0, 1518, 1518, 4'b0001};
    vecs[7]  = '{"loc63",  1,  63,  1, 0, 0,  63,   63,  4'b0101};
    vecs[8]  = '{"bc1519", 7,  1519, 0, 0, 0, 1519, 1519, 4'b0101};
    vecs[9]  = '{"pre16",  16, 64,  0, 0, 0,  0,    0,   4'b0010};
    vecs[10] = '{"one",    7,  1,   0, 1, 0,  1,    1,   4'b0100};
    vecs[11] = '{"empty",  7,  0,   0, 1, 0,  0,    0,   4'b0100};

    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs", {rx_data, rx_valid, rx_sop, rx_eop, frame_done, frame_len, frame_stat, good_cnt, bad_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Bad byte where the SFD should be: burst dropped, one bad status.
    base = rxq.size(); done0 = done_cnt;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hAA);
    for (int i = 0; i < 50; i++) drive(1'b1, 8'(i));
    idle(8);
    bad_exp++;
    check("drop.rx_bytes", 64'(rxq.size() - base), 64'd0);
    check("drop.done", 64'(done_cnt - done0), 64'd1);
    check("drop.pre_err", 64'(last_stat[1]), 64'd1);
    check("drop.bad", 64'(bad_cnt), 64'(bad_exp));

    // Carrier glitch inside the preamble: silently ignored.
    done0 = done_cnt;
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h55);
    idle(8);
    check("glitch.done", 64'(done_cnt - done0), 64'd0);
    check("glitch.counts", {32'(good_cnt), 32'(bad_cnt)}, {32'(good_exp), 32'(bad_exp)});

    // Reset pulse in the middle of a frame.
    promisc = 1'b0;
    build_frame(64, 0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, fb[i]);
    @(negedge clk);
    check("midrst.valid_before", 64'(rx_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.outputs", {rx_data, rx_valid, rx_sop, rx_eop, frame_done, frame_len, frame_stat, good_cnt, bad_cnt}, 64'd0);
    gmii_rx_dv = 1'b0;
    gmii_rx_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    good_exp = 0;
    bad_exp = 0;
    done0 = done_cnt;
    idle(8);
    check("midrst.no_done", 64'(done_cnt - done0), 64'd0);
    run_vec(vecs[0]);

    // Two frames separated by a two-cycle gap.
    base = rxq.size(); done0 = done_cnt;
    build_frame(64, 1, 1'b0);
    send(7);
    drive(1'b0, 8'h00);
    send(7);
    idle(8);
    good_exp += 2;
    check("b2b.done", 64'(done_cnt - done0), 64'd2);
    check("b2b.rx_bytes", 64'(rxq.size() - base), 64'd128);
    check("b2b.good", 64'(good_cnt), 64'(good_exp));
    check("b2b.second_tail", 64'(rxq[base + 127]), 64'(fb[63]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
